// File: rtl/sram_responder.sv
// sram_responder: behavioural model of an asynchronous-style 16-bit SRAM
// sitting on a clocked bus. After every reset it zero-fills the first
// INIT_WORDS words, then services byte-laned writes and fixed-latency
// reads on a bidirectional Data bus. The Ready and Acc_Count outputs are
// registered; the FSM state is exported on fsm_state for debug and checkers.
//
// Bus handshake (all control inputs active low, sampled at rising Clk):
//   write : CE=0, WE=0 at an edge commits the enabled byte lanes (UB/LB).
//           Each such edge with at least one lane enabled counts as one
//           access. WE=0 always wins over OE=0.
//   read  : CE=0, OE=0, WE=1 at an edge in IDLE captures ADDR/UB/LB.
//           Data is driven READ_LAT edges after capture (the capture edge
//           counts as the first) and stays driven while CE=0, OE=0, WE=1
//           and the decoded address is unchanged. Each drive entry counts
//           as one access.
module sram_responder #(
    parameter int ADDR_W     = 16,
    parameter int READ_LAT   = 2,
    parameter int INIT_WORDS = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic        UB,
    input  logic        LB,
    input  logic [19:0] ADDR,
    inout  wire  [15:0] Data,
    output logic        Ready,
    output logic [15:0] Acc_Count,
    output logic [1:0]  fsm_state
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(INIT_WORDS - 1);
    localparam logic [2:0]        WAIT_LAST = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_DRIVE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [2:0]        wait_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ub_n;
    logic              rd_lb_n;
    logic [15:0]       acc_cnt;
    logic              ready_q;

    logic [15:0]       mem [0:DEPTH-1];

    // Upper address bits are deliberately ignored (aliasing); this keeps the
    // whole ADDR bus referenced so the intent is visible.
    wire               unused_addr_hi = &{1'b0, ADDR};

    logic [ADDR_W-1:0] dec_addr;
    logic              rd_req;
    logic              wr_req;
    logic              wr_lane;
    logic [15:0]       rd_word;
    logic [15:0]       drv_word;
    logic              data_oe;

    // Decode of the raw bus controls into the three request kinds.
    always_comb begin
        dec_addr = ADDR[ADDR_W-1:0];
        rd_req   = !CE && !OE && WE;
        wr_req   = !CE && !WE;
        wr_lane  = !UB || !LB;
    end

    // Main FSM: init sweep, read capture/latency/drive, access counting.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            wait_cnt <= 3'd0;
            rd_addr  <= '0;
            rd_ub_n  <= 1'b1;
            rd_lb_n  <= 1'b1;
            acc_cnt  <= 16'h0000;
            ready_q  <= 1'b0;
        end else begin
            // Ready follows one edge after the sweep hands over to IDLE.
            if (state != ST_INIT) begin
                ready_q <= 1'b1;
            end
            case (state)
                ST_INIT: begin
                    // Bus is ignored; the memory block writes word init_cnt.
                    if (init_cnt == INIT_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        init_cnt <= init_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (wr_req) begin
                        if (wr_lane) begin
                            acc_cnt <= acc_cnt + 16'd1;
                        end
                    end else if (rd_req) begin
                        rd_addr <= dec_addr;
                        rd_ub_n <= UB;
                        rd_lb_n <= LB;
                        if (READ_LAT == 1) begin
                            state   <= ST_RD_DRIVE;
                            acc_cnt <= acc_cnt + 16'd1;
                        end else begin
                            state    <= ST_RD_WAIT;
                            wait_cnt <= 3'd1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (wr_req) begin
                        // A write aborts the pending read and is serviced.
                        state <= ST_IDLE;
                        if (wr_lane) begin
                            acc_cnt <= acc_cnt + 16'd1;
                        end
                    end else if (!rd_req) begin
                        // CE or OE released: drop the read, nothing counted.
                        state <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ST_RD_DRIVE;
                        acc_cnt <= acc_cnt + 16'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_RD_DRIVE: begin
                    if (wr_req) begin
                        state <= ST_IDLE;
                        if (wr_lane) begin
                            acc_cnt <= acc_cnt + 16'd1;
                        end
                    end else if (!rd_req) begin
                        state <= ST_IDLE;
                    end else if (dec_addr != rd_addr) begin
                        // New address: restart the full read latency. With a
                        // single-edge latency the recapture edge is itself the
                        // drive-entry edge.
                        rd_addr <= dec_addr;
                        rd_ub_n <= UB;
                        rd_lb_n <= LB;
                        if (READ_LAT == 1) begin
                            acc_cnt <= acc_cnt + 16'd1;
                        end else begin
                            state    <= ST_RD_WAIT;
                            wait_cnt <= 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Memory array: zero-fill during the init sweep, byte-laned bus writes
    // afterwards. The array has no reset; an edge with Reset high commits
    // nothing, so a write in flight when reset arrives is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= 16'h0000;
            end else if (wr_req) begin
                if (!UB) begin
                    mem[dec_addr][15:8] <= Data[15:8];
                end
                if (!LB) begin
                    mem[dec_addr][7:0] <= Data[7:0];
                end
            end
        end
    end

    // Read path: array read at the latched address, disabled lanes forced to
    // zero. Reading the array directly means a prior write is always seen.
    always_comb begin
        rd_word  = mem[rd_addr];
        drv_word = {rd_ub_n ? 8'h00 : rd_word[15:8],
                    rd_lb_n ? 8'h00 : rd_word[7:0]};
        // Registered state decode gated by the live controls: the bus is
        // released in the same cycle CE/OE rise, and never driven with WE=0.
        data_oe  = (state == ST_RD_DRIVE) && rd_req;
    end

    assign Data      = data_oe ? drv_word : 16'hzzzz;
    assign Ready     = ready_q;
    assign Acc_Count = acc_cnt;
    assign fsm_state = state;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed bench for sram_responder with a read-data
// scoreboard and a reference access counter.
module tb_sram_responder;

    localparam int ADDR_W     = 16;
    localparam int READ_LAT   = 2;
    localparam int INIT_WORDS = 16;

    logic        Clk;
    logic        Reset;
    logic        CE;
    logic        OE;
    logic        WE;
    logic        UB;
    logic        LB;
    logic [19:0] ADDR;
    wire  [15:0] Data;
    logic        Ready;
    logic [15:0] Acc_Count;
    logic [1:0]  fsm_state;

    logic        tb_drive;
    logic [15:0] tb_data;

    logic [15:0] exp_q[$];
    logic [15:0] exp_acc;
    int          n_cmp;
    int          n_fail;

    assign Data = tb_drive ? tb_data : 16'hzzzz;

    // Weak pull so an undriven bus reads as all ones in two-state simulators.
    for (genvar g = 0; g < 16; g++) begin : g_pull
        pullup (Data[g]);
    end

    sram_responder #(
        .ADDR_W     (ADDR_W),
        .READ_LAT   (READ_LAT),
        .INIT_WORDS (INIT_WORDS)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .CE        (CE),
        .OE        (OE),
        .WE        (WE),
        .UB        (UB),
        .LB        (LB),
        .ADDR      (ADDR),
        .Data      (Data),
        .Ready     (Ready),
        .Acc_Count (Acc_Count),
        .fsm_state (fsm_state)
    );

    // Clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_hiz(input string tag);
        logic ok;
        ok = (Data === 16'hzzzz) || (Data === 16'hffff);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected zzzz", tag, Data);
        end
    endtask

    task automatic bus_idle();
        CE       = 1'b1;
        OE       = 1'b1;
        WE       = 1'b1;
        UB       = 1'b0;
        LB       = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic wait_ready();
        int edges;
        edges = 0;
        while (!Ready && edges < 200) begin
            @(posedge Clk);
            #1;
            edges++;
        end
        check("ready_edges", 16'(edges), 16'(INIT_WORDS + 1));
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
        @(negedge Clk);
        ADDR     = a;
        tb_data  = d;
        tb_drive = 1'b1;
        UB       = ub;
        LB       = lb;
        CE       = 1'b0;
        WE       = 1'b0;
        OE       = 1'b1;
        @(posedge Clk);
        if (!ub || !lb) exp_acc = exp_acc + 16'd1;
        @(negedge Clk);
        bus_idle();
    endtask

    // Latency window after a capture edge, then the first driven word.
    task automatic read_tail();
        logic [15:0] exp;
        for (int i = 1; i < READ_LAT; i++) begin
            @(negedge Clk);
            check_hiz("rd_wait_hiz");
        end
        @(negedge Clk);
        exp_acc = exp_acc + 16'd1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("rd_data", Data, exp);
        check("rd_acc", Acc_Count, exp_acc);
    endtask

    task automatic start_read(input logic [19:0] a, input logic ub,
                              input logic lb, input logic [15:0] exp);
        exp_q.push_back(exp);
        @(negedge Clk);
        ADDR = a;
        UB   = ub;
        LB   = lb;
        CE   = 1'b0;
        OE   = 1'b0;
        WE   = 1'b1;
        #1;
        check_hiz("rd_setup_hiz");
        read_tail();
    endtask

    task automatic end_read();
        #2;
        OE = 1'b1;
        #1;
        check_hiz("oe_rise_hiz");
        CE = 1'b1;
        @(negedge Clk);
        bus_idle();
        check("end_acc", Acc_Count, exp_acc);
    endtask

    // Directed sequence
    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        exp_acc  = 16'h0000;
        Reset    = 1'b1;
        ADDR     = 20'h0;
        tb_data  = 16'h0;
        bus_idle();

        repeat (3) @(posedge Clk);
        #1;
        check("rst_ready", {15'b0, Ready}, 16'h0000);
        check("rst_acc", Acc_Count, 16'h0000);
        check_hiz("rst_hiz");
        @(negedge Clk);
        Reset = 1'b0;
        wait_ready();

        // Full-word write then read.
        do_write(20'h00040, 16'h1234, 1'b0, 1'b0);
        start_read(20'h00040, 1'b0, 1'b0, 16'h1234);
        end_read();
        check("acc_after_wr_rd", Acc_Count, 16'h0002);
        start_read(20'h00005, 1'b0, 1'b0, 16'h0000);
        end_read();

        // Byte lanes.
        do_write(20'h00040, 16'hABCD, 1'b0, 1'b1);
        start_read(20'h00040, 1'b0, 1'b0, 16'hAB34);
        end_read();
        start_read(20'h00040, 1'b1, 1'b0, 16'h0034);
        end_read();

        // Aliased write with OE also low: write wins, DUT stays off the bus.
        @(negedge Clk);
        ADDR     = 20'h10040;
        tb_data  = 16'h5555;
        tb_drive = 1'b1;
        UB       = 1'b0;
        LB       = 1'b0;
        CE       = 1'b0;
        OE       = 1'b0;
        WE       = 1'b0;
        #1;
        check("contend_bus", Data, 16'h5555);
        @(posedge Clk);
        exp_acc = exp_acc + 16'd1;
        @(negedge Clk);
        tb_drive = 1'b0;
        UB       = 1'b1;
        LB       = 1'b1;
        #1;
        check_hiz("we_oe_low_hiz");
        @(negedge Clk);
        check_hiz("we_oe_low_hiz2");
        check("no_lane_acc", Acc_Count, exp_acc);
        bus_idle();
        start_read(20'h00040, 1'b0, 1'b0, 16'h5555);
        end_read();

        // Address change while driving.
        do_write(20'h00041, 16'h2222, 1'b0, 1'b0);
        start_read(20'h00040, 1'b0, 1'b0, 16'h5555);
        ADDR = 20'h00041;
        #1;
        check("addr_chg_old", Data, 16'h5555);
        exp_q.push_back(16'h2222);
        read_tail();
        end_read();

        // OE release during RD_WAIT: abort, no count.
        @(negedge Clk);
        ADDR = 20'h00041;
        CE   = 1'b0;
        OE   = 1'b0;
        WE   = 1'b1;
        @(negedge Clk);
        check("rd_wait_state", {14'b0, fsm_state}, 16'h0002);
        OE = 1'b1;
        @(negedge Clk);
        check("abort_state", {14'b0, fsm_state}, 16'h0001);
        check("abort_acc", Acc_Count, exp_acc);
        check_hiz("abort_hiz");
        bus_idle();

        // Write during RD_WAIT: read dropped, write serviced.
        @(negedge Clk);
        ADDR = 20'h00041;
        CE   = 1'b0;
        OE   = 1'b0;
        WE   = 1'b1;
        @(negedge Clk);
        tb_data  = 16'h7777;
        tb_drive = 1'b1;
        WE       = 1'b0;
        @(posedge Clk);
        exp_acc = exp_acc + 16'd1;
        @(negedge Clk);
        bus_idle();
        check("wr_abort_state", {14'b0, fsm_state}, 16'h0001);
        check("wr_abort_acc", Acc_Count, exp_acc);
        start_read(20'h00041, 1'b0, 1'b0, 16'h7777);
        end_read();

        // WE held low over two edges counts twice.
        @(negedge Clk);
        ADDR     = 20'h00042;
        tb_data  = 16'h0F0F;
        tb_drive = 1'b1;
        CE       = 1'b0;
        WE       = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        exp_acc = exp_acc + 16'd2;
        @(negedge Clk);
        bus_idle();
        check("we_hold_acc", Acc_Count, exp_acc);
        start_read(20'h00042, 1'b0, 1'b1, 16'h0F00);
        end_read();

        // Reset while driving.
        start_read(20'h00040, 1'b0, 1'b0, 16'h5555);
        #2;
        Reset = 1'b1;
        #1;
        check_hiz("rst_mid_hiz");
        check("rst_mid_ready", {15'b0, Ready}, 16'h0000);
        check("rst_mid_acc", Acc_Count, 16'h0000);
        bus_idle();
        exp_acc = 16'h0000;
        @(negedge Clk);
        Reset = 1'b0;
        wait_ready();
        start_read(20'h00040, 1'b0, 1'b0, 16'h5555);
        end_read();
        start_read(20'h00005, 1'b0, 1'b0, 16'h0000);
        end_read();
        check("final_acc", Acc_Count, 16'h0002);
        check("queue_empty", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
